// File: rtl/get_window_kxk.sv
// Streaming KxK window generator with internal line buffers.
// Emits in-image windows tagged with the bottom-right pixel position.
module get_window_kxk #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 3,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic                                    in_sof,
  input  logic [DATA_WIDTH-1:0]                   in_data,
  output logic                                    out_valid,
  output logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0] win_data,
  output logic [ROW_W-1:0]                        out_row,
  output logic [COL_W-1:0]                        out_col,
  output logic                                    frame_done
);

  localparam int K  = WIN_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int NB = K - 1;
  localparam int WW = K * K * DW;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_K1   = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_K1   = ROW_W'(K - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] pos_c;
  logic [ROW_W-1:0] pos_r;

  logic             vld_q, vld_d;
  logic             fd_q, fd_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [WW-1:0]    win_q, win_d;

  logic [DW-1:0] lb_mem [NB][IMG_WIDTH];
  logic [DW-1:0] lb_rd  [NB];

  // Position of the pixel on the input: sof forces the frame origin
  always_comb begin
    pos_c = in_sof ? '0 : col_q;
    pos_r = in_sof ? '0 : row_q;
  end

  // Read-before-write line buffer taps at the current column
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      lb_rd[k] = lb_mem[k][pos_c];
    end
  end

  // Line buffers cascade: newest row enters lb[0], older rows move down
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb_mem[0][pos_c] <= in_data;
      for (int k = 1; k < NB; k++) begin
        lb_mem[k][pos_c] <= lb_rd[k-1];
      end
    end
  end

  // Window shift: every row moves left, new column from buffers and input
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win_d[(i*K+j)*DW +: DW] = win_q[(i*K+j+1)*DW +: DW];
        end
      end
      win_d[((K-1)*K+K-1)*DW +: DW] = in_data;
      for (int m = 1; m < K; m++) begin
        win_d[((K-1-m)*K+K-1)*DW +: DW] = lb_rd[m-1];
      end
    end
  end

  // Raster counters, output flags and position tags
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    vld_d  = 1'b0;
    fd_d   = 1'b0;
    orow_d = orow_q;
    ocol_d = ocol_q;
    if (in_valid) begin
      vld_d  = (pos_r >= ROW_K1) && (pos_c >= COL_K1);
      orow_d = pos_r;
      ocol_d = pos_c;
      if (pos_c == COL_LAST) begin
        col_d = '0;
        if (pos_r == ROW_LAST) begin
          row_d = '0;
          fd_d  = 1'b1;
        end else begin
          row_d = pos_r + 1'b1;
        end
      end else begin
        col_d = pos_c + 1'b1;
        row_d = pos_r;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      fd_q   <= 1'b0;
      orow_q <= '0;
      ocol_q <= '0;
      win_q  <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_q  <= vld_d;
      fd_q   <= fd_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      win_q  <= win_d;
    end
  end

  assign out_valid  = vld_q;
  assign frame_done = fd_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;
  assign win_data   = win_q;

endmodule
